wd_service_ctrl: RTL and testbench

- Servicing side of the CRC engine's watchdog timer.
- Arms the watchdog when a CRC job starts and kicks it (clear pulse) on engine progress, rate-limited.
- Reacts to a watchdog timeout: aborts the engine, waits for the engine to drain, then re-arms or escalates to a sticky fatal error after MAX_RETRY consecutive timeouts.
- Sits between the CRC engine control path and the watchdog timer.

---
 rtl/wd_service_ctrl.sv | 151 +++++++++++++++
 tb/tb_wd_service_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_service_ctrl.sv
// Watchdog servicing controller for the CRC engine.
// Arms the watchdog on job start and kicks it on engine progress, at most
// once every KICK_GAP cycles. On a watchdog timeout it aborts the engine,
// waits for the engine to drain, then returns to IDLE flagging a retry, or
// latches a sticky fatal error after MAX_RETRY consecutive timeouts.
module wd_service_ctrl #(
  parameter int WD_CNT_W  = 16,
  parameter int KICK_GAP  = 8,
  parameter int RETRY_W   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_done,
  input  logic                i_progress,
  input  logic                i_engine_idle,
  input  logic [WD_CNT_W-1:0] i_timeout_val,
  input  logic                i_sw_clr,
  input  logic                i_wd_irq,
  output logic                o_wd_en,
  output logic                o_wd_clear,
  output logic [WD_CNT_W-1:0] o_wd_val,
  output logic                o_abort,
  output logic                o_retry,
  output logic                o_fatal,
  output logic [RETRY_W-1:0]  o_timeout_cnt
);

  // Gap counter holds 0..KICK_GAP-1; keep at least one bit for KICK_GAP==1.
  localparam int GAP_W = (KICK_GAP > 1) ? $clog2(KICK_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(KICK_GAP - 1);
  localparam logic [RETRY_W-1:0] MAX_CNT    = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RECOVER,
    S_DRAIN,
    S_FATAL
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;   // cycles left before another kick is allowed
  logic             kick_pend; // progress seen while kicks were rate-limited

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      kick_pend     <= 1'b0;
      o_wd_en       <= 1'b0;
      o_wd_clear    <= 1'b0;
      o_wd_val      <= '0;
      o_abort       <= 1'b0;
      o_retry       <= 1'b0;
      o_fatal       <= 1'b0;
      o_timeout_cnt <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only by
      // the branch that wants them; non-blocking assignments let a later
      // branch override the default without ordering hazards.
      o_wd_clear <= 1'b0;
      o_abort    <= 1'b0;
      o_retry    <= 1'b0;

      if (i_sw_clr) begin
        // Software clear wins over everything else in the same cycle.
        state         <= S_IDLE;
        o_wd_en       <= 1'b0;
        o_wd_clear    <= 1'b1;
        o_fatal       <= 1'b0;
        o_timeout_cnt <= '0;
        gap_cnt       <= '0;
        kick_pend     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            // The watchdog reloads on the rising edge of o_wd_en, so no
            // kick is needed when arming.
            if (i_start) begin
              state    <= S_ARMED;
              o_wd_en  <= 1'b1;
              o_wd_val <= i_timeout_val;
            end
          end

          S_ARMED: begin
            if (i_wd_irq) begin
              state     <= S_RECOVER;
              o_wd_en   <= 1'b0;
              o_abort   <= 1'b1;
              gap_cnt   <= '0;
              kick_pend <= 1'b0;
              if (o_timeout_cnt != MAX_CNT) begin
                o_timeout_cnt <= o_timeout_cnt + 1'b1;
              end
            end else if (i_done) begin
              state         <= S_IDLE;
              o_wd_en       <= 1'b0;
              o_wd_clear    <= 1'b1;
              o_timeout_cnt <= '0;
              gap_cnt       <= '0;
              kick_pend     <= 1'b0;
            end else if (gap_cnt == '0) begin
              // Kick window open: serve fresh or deferred progress once.
              if (i_progress || kick_pend) begin
                o_wd_clear <= 1'b1;
                gap_cnt    <= GAP_RELOAD;
                kick_pend  <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
              if (i_progress) begin
                kick_pend <= 1'b1;
              end
            end
          end

          S_RECOVER: begin
            state <= S_DRAIN;
          end

          S_DRAIN: begin
            if (i_engine_idle) begin
              if (o_timeout_cnt == MAX_CNT) begin
                state   <= S_FATAL;
                o_fatal <= 1'b1;
              end else begin
                // Clearing the watchdog also drops its pending interrupt.
                state      <= S_IDLE;
                o_wd_clear <= 1'b1;
                o_retry    <= 1'b1;
              end
            end
          end

          S_FATAL: begin
            o_fatal <= 1'b1;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wd_service_ctrl.sv
// Self-checking bench for wd_service_ctrl: directed scenarios followed by
// random traffic, all scored cycle by cycle against a behavioural model.
module tb_wd_service_ctrl;

  localparam int WD_CNT_W  = 16;
  localparam int KICK_GAP  = 8;
  localparam int RETRY_W   = 4;
  localparam int MAX_RETRY = 3;
  localparam int OUT_W     = WD_CNT_W + RETRY_W + 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, done, progress, engine_idle, sw_clr, wd_irq;
  logic [WD_CNT_W-1:0] timeout_val;
  logic                o_wd_en, o_wd_clear, o_abort, o_retry, o_fatal;
  logic [WD_CNT_W-1:0] o_wd_val;
  logic [RETRY_W-1:0]  o_timeout_cnt;
  logic [OUT_W-1:0]    dut_out;

  always #5 clk = ~clk;

  wd_service_ctrl #(
    .WD_CNT_W (WD_CNT_W),
    .KICK_GAP (KICK_GAP),
    .RETRY_W  (RETRY_W),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_done       (done),
    .i_progress   (progress),
    .i_engine_idle(engine_idle),
    .i_timeout_val(timeout_val),
    .i_sw_clr     (sw_clr),
    .i_wd_irq     (wd_irq),
    .o_wd_en      (o_wd_en),
    .o_wd_clear   (o_wd_clear),
    .o_wd_val     (o_wd_val),
    .o_abort      (o_abort),
    .o_retry      (o_retry),
    .o_fatal      (o_fatal),
    .o_timeout_cnt(o_timeout_cnt)
  );

  assign dut_out = {o_wd_en, o_wd_clear, o_wd_val, o_abort, o_retry, o_fatal, o_timeout_cnt};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phases of a job's life as seen from outside the controller.
  localparam int P_OFF = 0, P_WATCH = 1, P_ABORTED = 2, P_WAIT_IDLE = 3, P_DEAD = 4;

  int                  m_phase = P_OFF;
  bit                  m_en, m_clear, m_abort, m_retry, m_fatal;
  int                  m_cnt   = 0;
  logic [WD_CNT_W-1:0] m_val   = '0;
  int                  m_edge  = 0;  // clock edges since time zero
  int                  m_last_kick;  // edge of the latest rate-limited kick
  bit                  m_kicked;     // a rate-limited kick happened this arming
  bit                  m_pend;       // progress awaiting the kick window

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] mon_exp;

  task automatic model_step();
    bit window_open;
    m_clear = 0;
    m_abort = 0;
    m_retry = 0;
    if (!rst_n) begin
      m_phase = P_OFF; m_en = 0; m_fatal = 0; m_cnt = 0; m_val = '0;
      m_kicked = 0; m_pend = 0;
    end else if (sw_clr) begin
      m_phase = P_OFF; m_en = 0; m_fatal = 0; m_cnt = 0; m_clear = 1;
      m_kicked = 0; m_pend = 0;
    end else begin
      case (m_phase)
        P_OFF: if (start) begin
          m_phase = P_WATCH; m_en = 1; m_val = timeout_val;
          m_kicked = 0; m_pend = 0;
        end
        P_WATCH: begin
          if (wd_irq) begin
            m_phase = P_ABORTED; m_en = 0; m_abort = 1;
            m_cnt = (m_cnt + 1 > MAX_RETRY) ? MAX_RETRY : m_cnt + 1;
          end else if (done) begin
            m_phase = P_OFF; m_en = 0; m_clear = 1; m_cnt = 0;
          end else begin
            window_open = !m_kicked || (m_edge - m_last_kick >= KICK_GAP);
            if (window_open && (progress || m_pend)) begin
              m_clear = 1; m_last_kick = m_edge; m_kicked = 1; m_pend = 0;
            end else if (!window_open && progress) begin
              m_pend = 1;
            end
          end
        end
        P_ABORTED: m_phase = P_WAIT_IDLE;
        P_WAIT_IDLE: if (engine_idle) begin
          if (m_cnt == MAX_RETRY) begin
            m_phase = P_DEAD; m_fatal = 1;
          end else begin
            m_phase = P_OFF; m_clear = 1; m_retry = 1;
          end
        end
        default: ;
      endcase
    end
    m_edge++;
    exp_q.push_back({m_en, m_clear, m_val, m_abort, m_retry, m_fatal, RETRY_W'(m_cnt)});
  endtask

  // Drive one cycle of inputs at the falling edge, predict, wait a cycle.
  task automatic cycle(input bit st, input bit dn, input bit pg, input bit idl,
                       input bit irq, input bit clr);
    start = st; done = dn; progress = pg; engine_idle = idl; wd_irq = irq; sw_clr = clr;
    model_step();
    @(negedge clk);
  endtask

  task automatic quiet(input int n, input bit idl);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, idl, 0, 0);
  endtask

  // Timeout round trip: arm, time out, drain once the engine goes idle.
  task automatic timeout_round();
    cycle(1, 0, 0, 0, 0, 0);
    quiet(2, 0);
    cycle(0, 0, 0, 0, 1, 0);
    quiet(2, 0);
    cycle(0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: every cycle, compare what the DUT presents with the prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("outputs", dut_out, mon_exp);
      end
    end
  end

  int kicks;
  int kick_at[$];

  initial begin
    rst_n = 1'b0;
    start = 0; done = 0; progress = 0; engine_idle = 0; wd_irq = 0; sw_clr = 0;
    timeout_val = '0;
    @(negedge clk);
    quiet(3, 0);
    check("reset_state", dut_out, '0);
    rst_n = 1'b1;
    quiet(2, 0);

    // Arm, then complete the job.
    timeout_val = 16'h0010;
    cycle(1, 0, 0, 0, 0, 0);
    check("arm_val", o_wd_val, 16'h0010);
    check("arm_en", o_wd_en, 1);
    check("arm_no_kick", o_wd_clear, 0);
    quiet(3, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("done_kick", o_wd_clear, 1);
    check("done_en", o_wd_en, 0);
    quiet(1, 0);
    check("done_kick_single", o_wd_clear, 0);

    // Continuous progress: kicks rate-limited to one per KICK_GAP cycles.
    cycle(1, 0, 0, 0, 0, 0);
    kicks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      if (o_wd_clear) begin
        kicks++;
        kick_at.push_back(i);
      end
    end
    check("burst_kicks", kicks, 3);
    check("burst_first_kick", (kick_at.size() > 0) ? kick_at[0] : -1, 0);
    check("burst_spacing", (kick_at.size() > 1) ? kick_at[1] - kick_at[0] : -1, KICK_GAP);
    quiet(6, 0);

    // Timeout wins over done and progress in the same cycle.
    cycle(0, 1, 1, 0, 1, 0);
    check("irq_abort", o_abort, 1);
    check("irq_cnt", o_timeout_cnt, 1);
    check("irq_no_kick", o_wd_clear, 0);
    quiet(5, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("drain_retry", o_retry, 1);
    check("drain_kick", o_wd_clear, 1);

    // Three consecutive timeouts escalate to fatal.
    cycle(0, 0, 0, 0, 0, 1);
    for (int r = 0; r < MAX_RETRY; r++) timeout_round();
    check("fatal_flag", o_fatal, 1);
    check("fatal_cnt", o_timeout_cnt, MAX_RETRY);
    cycle(1, 0, 0, 0, 0, 0);
    check("fatal_start_ignored", o_wd_en, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check("swclr_fatal", o_fatal, 0);
    check("swclr_cnt", o_timeout_cnt, 0);
    check("swclr_kick", o_wd_clear, 1);

    // A completed job resets the consecutive count.
    timeout_round();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("done_clears_cnt", o_timeout_cnt, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("cnt_restarts", o_timeout_cnt, 1);

    // Asynchronous reset while draining.
    quiet(3, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out, '0);
    quiet(2, 0);
    rst_n = 1'b1;
    timeout_val = 16'h1234;
    cycle(1, 0, 0, 0, 0, 0);
    check("post_reset_arm", o_wd_en, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      timeout_val = WD_CNT_W'($urandom);
      cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 5,  $urandom_range(0, 199) < 1);
    end

    quiet(2, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
